// File: rtl/serial_adder_driver.sv
// -----------------------------------------------------------------------------
// serial_adder_driver
//
// Transmit side of the bit-serial add interface. Operand pairs are accepted in
// parallel over a valid/ready handshake and shifted out LSB-first, one bit pair
// per beat. The final beat of each word is marked with ser_last. Raising pause
// while a word is in flight inserts a vld-low bubble and freezes all state.
//
// Handshakes: a transfer happens on a posedge where in_vld & in_rdy are both
// high. in_rdy never depends on in_vld. Serial beats have no back-pressure: a
// beat is consumed by the adder on every posedge where ser_vld is high, and the
// adder returns the matching sum bit on ser_sum in the same cycle.
//
// Configuration macro: SERIAL_ADDER_DRIVER_RESULT_EN
//   defined   : returned sum bits are collected; res_vld pulses one cycle after
//               each last beat and res holds the word until the next pulse.
//   undefined : no sum register, ser_sum ignored, res_vld/res tied to 0.
//
// Ports
//   clk      clock, all state changes on posedge
//   rst      asynchronous reset, active-low
//   in_vld   operand pair offered
//   in_rdy   pair can be accepted this cycle
//   in_a     operand A (WIDTH)
//   in_b     operand B (WIDTH)
//   pause    1 = emit no beat this cycle
//   ser_vld  serial bit pair valid
//   ser_a    serial bit of A, LSB first
//   ser_b    serial bit of B, LSB first
//   ser_last final beat of the word (only with ser_vld)
//   ser_sum  sum bit from the adder, same cycle as the beat
//   res_vld  one-cycle pulse, res holds a completed sum
//   res      collected sum word, modulo 2^WIDTH (WIDTH)
// -----------------------------------------------------------------------------
module serial_adder_driver #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             pause,
   output logic             ser_vld,
   output logic             ser_a,
   output logic             ser_b,
   output logic             ser_last,
   input  logic             ser_sum,
   output logic             res_vld,
   output logic [WIDTH-1:0] res
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [CW-1:0]    cnt;
   logic             accept;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake/serial outputs
   always_comb begin
      state_nxt = state;
      ser_vld   = 1'b0;
      ser_last  = 1'b0;
      in_rdy    = 1'b0;

      ser_vld  = (state == SHIFT) & ~pause;
      ser_last = ser_vld & (cnt == CNT_LAST);
      // Ready on the last beat as well, so a waiting pair follows with no gap.
      in_rdy   = (state == IDLE) | ser_last;

      case (state)
         IDLE:    if (in_vld) state_nxt = SHIFT;
         SHIFT:   if (ser_last && !in_vld) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = in_vld & in_rdy;
   assign ser_a  = sh_a[0];
   assign ser_b  = sh_b[0];

   // Operand shift registers and beat counter. A load on the last beat takes
   // priority over the shift of the finishing word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_a <= '0;
         sh_b <= '0;
         cnt  <= '0;
      end else if (accept) begin
         sh_a <= in_a;
         sh_b <= in_b;
         cnt  <= '0;
      end else if (ser_vld) begin
         sh_a <= sh_a >> 1;
         sh_b <= sh_b >> 1;
         cnt  <= ser_last ? '0 : cnt + CW'(1);
      end
   end

`ifdef SERIAL_ADDER_DRIVER_RESULT_EN
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_nxt;

   // Sum bits arrive LSB first, so they enter at the MSB end; after WIDTH
   // beats the first bit has reached bit 0.
   generate
      if (WIDTH > 1) begin : g_sum_wide
         assign sum_nxt = {ser_sum, sum_sh[WIDTH-1:1]};
      end else begin : g_sum_one
         assign sum_nxt = ser_sum;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_sh  <= '0;
         res     <= '0;
         res_vld <= 1'b0;
      end else begin
         res_vld <= ser_last;
         if (ser_vld) begin
            sum_sh <= sum_nxt;
         end
         if (ser_last) begin
            res <= sum_nxt;
         end
      end
   end
`else
   logic unused_ser_sum;
   assign unused_ser_sum = ser_sum;
   assign res_vld        = 1'b0;
   assign res            = '0;
`endif

endmodule
